// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access stage.
// Exports the access-width and FSM-state enums.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_BYTE = 2'd1,
        MEM_HALF = 2'd2,
        MEM_WORD = 2'd3
    } mem_width_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_aligner.sv
// Load lane select and sign/zero extension (combinational).
// Ports: rdata word, offset = addr[1:0], width, load_unsigned -> data.
module load_aligner
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_width_t  width,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = rdata;
        unique case (width)
            MEM_BYTE: data = load_unsigned ?
                             {24'b0, shifted[7:0]} :
                             {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: data = load_unsigned ?
                             {16'b0, shifted[15:0]} :
                             {{16{shifted[15]}}, shifted[15:0]};
            MEM_WORD: data = rdata;
            MEM_NONE: data = rdata;
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: drives a req/ack data-memory port, returns extended
// load data or store completion, stalls upstream while busy.
// Ports: in_* ALU-side op, out_* writeback result, dmem_* memory bus.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        mem_width,
    input  logic              load_unsigned,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misaligned,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] addr_q;
    mem_width_t        width_q;
    logic              uns_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] res_q, res_d;
    logic              mis_q, mis_d;
    logic              cap;

    mem_width_t        w_in;
    logic              mem_op;
    logic              misal;
    logic [3:0]        be_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] ld_data;

    assign w_in   = mem_width_t'(mem_width);
    assign mem_op = (w_in != MEM_NONE) && (is_load || is_store);
    assign misal  = ((w_in == MEM_HALF) && addr[0]) ||
                    ((w_in == MEM_WORD) && (addr[1:0] != 2'b00));

    always_comb begin
        be_in    = 4'b0000;
        wdata_in = store_data;
        unique case (w_in)
            MEM_BYTE: begin
                be_in    = 4'b0001 << addr[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            MEM_HALF: begin
                be_in    = 4'b0011 << addr[1:0];
                wdata_in = {2{store_data[15:0]}};
            end
            MEM_WORD: begin
                be_in    = 4'b1111;
                wdata_in = store_data;
            end
            MEM_NONE: be_in = 4'b0000;
            default:  be_in = 4'b0000;
        endcase
    end

    load_aligner u_align (
        .rdata         (dmem_rdata),
        .offset        (addr_q[1:0]),
        .width         (width_q),
        .load_unsigned (uns_q),
        .data          (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        res_d     = res_q;
        mis_d     = mis_q;
        cap       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    res_d = '0;
                    mis_d = 1'b0;
                    if (!mem_op) begin
                        state_d = S_RESP;
                    end else if (misal) begin
                        state_d = S_RESP;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cap     = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // A flush here cannot cancel the bus cycle; remember it
                // and drop the result once the memory acks.
                discard_d = discard_q | flush;
                if (dmem_ack) begin
                    res_d     = we_q ? '0 : ld_data;
                    mis_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = (discard_q || flush) ? S_IDLE : S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            addr_q    <= '0;
            width_q   <= MEM_NONE;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            res_q     <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            res_q     <= res_d;
            mis_q     <= mis_d;
            if (cap) begin
                addr_q  <= addr;
                width_q <= w_in;
                uns_q   <= load_unsigned;
                we_q    <= is_store;
                be_q    <= be_in;
                wdata_q <= wdata_in;
            end
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign stall          = (state_q != S_IDLE) ||
                            (in_valid && mem_op && !misal);
    assign out_valid      = (state_q == S_RESP) && !flush;
    assign out_misaligned = out_valid && mis_q;
    assign out_data       = out_valid ? res_q : '0;

    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = dmem_req && we_q;
    assign dmem_addr  = dmem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? be_q : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops plus a per-cycle
// reference model checked on every negedge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [1:0]  mem_width = 2'd0;
    logic        load_unsigned = 1'b0;
    logic        flush = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic        in_ready, out_valid, out_misaligned, stall;
    logic [31:0] out_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_BYTE = 2'd1;
    localparam logic [1:0] W_HALF = 2'd2;
    localparam logic [1:0] W_WORD = 2'd3;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .is_load        (is_load),
        .is_store       (is_store),
        .addr           (addr),
        .store_data     (store_data),
        .mem_width      (mem_width),
        .load_unsigned  (load_unsigned),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_misaligned (out_misaligned),
        .stall          (stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h",
                     name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'd1:    return 1;
            2'd2:    return 2;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be_f(input int n, input int off);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + n) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wd_f(input int n,
                                           input logic [31:0] sd);
        logic [31:0] wd;
        wd = '0;
        for (int i = 0; i < 4; i++)
            wd = wd | (((sd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return wd;
    endfunction

    function automatic logic [31:0] m_ld_f(input logic [31:0] rd,
                                           input int off, input int n,
                                           input bit uns);
        logic [31:0] mask, v;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
        v = (rd >> (8 * off)) & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model: ph 0 = free, 1 = bus cycle open, 2 = result due.
    int          ph = 0;
    bit          synced = 0;
    bit          disc = 0;
    bit          m_mis = 0;
    bit          m_we = 0;
    bit          m_uns = 0;
    int          m_n = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_be = '0;

    always @(negedge clk) begin
        int  n;
        bit  memop, algn, e_ov;
        n = nbytes(mem_width);
        memop = (n > 0) && (is_load || is_store);
        algn = (n > 0) && ((addr % n) == 0);
        if (synced) begin
            e_ov = (ph == 2) && !flush;
            chk("m_in_ready", 32'(in_ready), 32'(ph == 0));
            chk("m_stall", 32'(stall),
                32'((ph != 0) || (in_valid && memop && algn)));
            chk("m_dmem_req", 32'(dmem_req), 32'(ph == 1));
            chk("m_out_valid", 32'(out_valid), 32'(e_ov));
            if (e_ov) begin
                chk("m_out_data", out_data, m_data);
                chk("m_out_mis", 32'(out_misaligned), 32'(m_mis));
            end
            if (ph == 1) begin
                chk("m_dmem_addr", dmem_addr, m_addr & 32'hFFFF_FFFC);
                chk("m_dmem_be", 32'(dmem_be), 32'(m_be));
                chk("m_dmem_we", 32'(dmem_we), 32'(m_we));
                if (m_we) chk("m_dmem_wdata", dmem_wdata, m_wd);
            end
        end
        if (rst) begin
            ph = 0;
            disc = 0;
            synced = 1;
        end else if (ph == 0) begin
            if (in_valid && !flush) begin
                m_data = 0;
                m_mis = 0;
                if (!memop) ph = 2;
                else if (!algn) begin
                    ph = 2;
                    m_mis = 1;
                end else begin
                    ph = 1;
                    m_n = n;
                    m_addr = addr;
                    m_we = is_store;
                    m_uns = load_unsigned;
                    m_be = m_be_f(n, int'(addr % 4));
                    m_wd = m_wd_f(n, store_data);
                end
            end
        end else if (ph == 1) begin
            if (flush) disc = 1;
            if (dmem_ack) begin
                m_data = m_we ? 32'h0 :
                         m_ld_f(dmem_rdata, int'(m_addr % 4), m_n, m_uns);
                ph = disc ? 0 : 2;
                disc = 0;
            end
        end else begin
            ph = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 0;
        is_load = 0;
        is_store = 0;
        flush = 0;
        dmem_ack = 0;
        load_unsigned = 0;
        mem_width = W_NONE;
    endtask

    task automatic issue(input bit ld, input bit st, input logic [1:0] w,
                         input bit u, input logic [31:0] a,
                         input logic [31:0] sd);
        in_valid = 1;
        is_load = ld;
        is_store = st;
        mem_width = w;
        load_unsigned = u;
        addr = a;
        store_data = sd;
    endtask

    task automatic load_op(input logic [1:0] w, input bit u,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp, input string name);
        issue(1, 0, w, u, a, 0);
        step();
        clr();
        dmem_ack = 1;
        dmem_rdata = rd;
        step();
        clr();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, out_data, exp);
        step();
    endtask

    initial begin
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        step();

        issue(0, 1, W_BYTE, 0, 32'h1003, 32'h12AB);
        #1;
        chk("sb_stall_accept", 32'(stall), 32'd1);
        step();
        clr();
        chk("sb_req", 32'(dmem_req), 32'd1);
        chk("sb_be", 32'(dmem_be), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_we", 32'(dmem_we), 32'd1);
        chk("sb_addr", dmem_addr, 32'h1000);
        dmem_ack = 1;
        step();
        clr();
        chk("sb_valid", 32'(out_valid), 32'd1);
        chk("sb_data", out_data, 32'h0);
        step();
        chk("sb_pulse_end", 32'(out_valid), 32'd0);

        load_op(W_BYTE, 0, 32'h1002, 32'h00F00000, 32'hFFFFFFF0, "lb");
        load_op(W_BYTE, 1, 32'h1002, 32'h00F00000, 32'h000000F0, "lbu");
        load_op(W_HALF, 0, 32'h1002, 32'h80011234, 32'hFFFF8001, "lh");
        load_op(W_HALF, 1, 32'h1002, 32'h80011234, 32'h00008001, "lhu");

        issue(1, 0, W_HALF, 0, 32'h1001, 0);
        #1;
        chk("lhmis_stall", 32'(stall), 32'd0);
        step();
        clr();
        chk("lhmis_valid", 32'(out_valid), 32'd1);
        chk("lhmis_flag", 32'(out_misaligned), 32'd1);
        chk("lhmis_data", out_data, 32'h0);
        chk("lhmis_req", 32'(dmem_req), 32'd0);
        step();
        chk("lhmis_ready", 32'(in_ready), 32'd1);

        issue(1, 0, W_WORD, 0, 32'h2004, 0);
        step();
        clr();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_req", 32'(dmem_req), 32'd1);
            chk("lw_wait_addr", dmem_addr, 32'h2004);
            chk("lw_wait_stall", 32'(stall), 32'd1);
            chk("lw_wait_ready", 32'(in_ready), 32'd0);
            step();
        end
        dmem_ack = 1;
        dmem_rdata = 32'hDEADBEEF;
        step();
        clr();
        chk("lw_valid", 32'(out_valid), 32'd1);
        chk("lw_data", out_data, 32'hDEADBEEF);
        step();

        issue(1, 0, W_WORD, 0, 32'h3000, 0);
        step();
        clr();
        step();
        flush = 1;
        step();
        flush = 0;
        dmem_ack = 1;
        dmem_rdata = 32'h11111111;
        chk("lwfl_req_held", 32'(dmem_req), 32'd1);
        step();
        clr();
        chk("lwfl_no_valid", 32'(out_valid), 32'd0);
        chk("lwfl_ready", 32'(in_ready), 32'd1);
        step();

        issue(1, 0, W_WORD, 0, 32'h4000, 0);
        step();
        clr();
        chk("rstreq_req", 32'(dmem_req), 32'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rstreq_req_drop", 32'(dmem_req), 32'd0);
        chk("rstreq_valid", 32'(out_valid), 32'd0);
        chk("rstreq_ready", 32'(in_ready), 32'd1);
        step();

        issue(0, 0, W_WORD, 0, 32'h5000, 0);
        #1;
        chk("nop_stall", 32'(stall), 32'd0);
        step();
        clr();
        chk("nop_valid", 32'(out_valid), 32'd1);
        chk("nop_data", out_data, 32'h0);
        chk("nop_mis", 32'(out_misaligned), 32'd0);
        step();

        issue(0, 0, W_NONE, 0, 32'h5000, 0);
        step();
        clr();
        flush = 1;
        #1;
        chk("respfl_valid", 32'(out_valid), 32'd0);
        step();
        clr();

        issue(1, 0, W_WORD, 0, 32'h6000, 0);
        flush = 1;
        step();
        clr();
        chk("idlefl_ready", 32'(in_ready), 32'd1);
        chk("idlefl_req", 32'(dmem_req), 32'd0);
        chk("idlefl_valid", 32'(out_valid), 32'd0);
        step();

        issue(0, 1, W_HALF, 0, 32'h1002, 32'h5555BEEF);
        step();
        clr();
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        dmem_ack = 1;
        step();
        clr();
        chk("sh_valid", 32'(out_valid), 32'd1);
        step();

        issue(0, 1, W_WORD, 0, 32'h1006, 32'h1);
        step();
        clr();
        chk("swmis_flag", 32'(out_misaligned), 32'd1);
        chk("swmis_req", 32'(dmem_req), 32'd0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
